alu_cmd_responder: RTL and testbench
====================================

Name: alu_cmd_responder

Overview:
- Sequential ALU command responder: the command-consuming end of the ALU stimulus/response interface.
- Accepts {A, B, OP} commands over a valid/ready handshake and computes the result, multi-cycle for multiply.
- Returns result plus carry/zero flags over a second valid/ready handshake.
- Sits between any command initiator (bench driver or future controller) and the datapath. Replaces directly-wired ALU instances where flow control is needed.

Parameters:
- WIDTH, 4, operand and result width in bits.
- OPW, 3, opcode width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  responder can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  OPW  opcode.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  result.
- rsp_carry  out  1  carry / borrow / multiply-overflow flag.
- rsp_zero  out  1  high when rsp_result == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). Every flop is cleared by rst_n.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, busy=0, state=IDLE.
- cmd_ready is registered. It is 1 in the first cycle after rst_n deasserts, and is 1 only in IDLE.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge N, capture a/b/op, go to EXEC.
  - EXEC (1 cycle): ops 000-110 compute, register result and flags, go to RESP. Op 111 initialises the multiplier (acc=0, count=0), go to MUL.
  - MUL: one shift-add step per cycle. After WIDTH steps, register result and flags, go to RESP.
  - RESP: rsp_valid=1. On rsp_valid&&rsp_ready, go to IDLE with rsp_valid=0.
- Latency:
  - Ops 000-110: rsp_valid first high after edge N+1.
  - Op 111: rsp_valid first high after edge N+1+WIDTH (edge N+5 for WIDTH=4).
- Throughput: at most one command in flight, with at least one IDLE cycle between responses.
- Handshake rules:
  - rsp_result, rsp_carry and rsp_zero hold stable while rsp_valid=1 and rsp_ready=0.
  - cmd_valid is ignored outside IDLE; no command is dropped or queued.
  - rsp_ready is ignored when rsp_valid=0.
  - rsp_ready may be high before rsp_valid. The response then completes in its first RESP cycle.
- Opcodes and arithmetic (all modulo 2^WIDTH, unsigned):
  - 000 ADD: result = a+b; carry = bit WIDTH of the sum.
  - 001 SUB: result = a-b; carry = borrow (a<b).
  - 010 AND, 011 OR, 100 XOR: bitwise; carry=0.
  - 101 NOT: result = ~a; b ignored; carry=0.
  - 110 SHL: result = a<<b, logical; b>=WIDTH gives 0; carry=0.
  - 111 MUL: 2*WIDTH product; result = low WIDTH bits; carry = OR of the high WIDTH bits.
- Flags: zero is computed from the registered result in all cases.
- Reset mid-operation: rst_n low in any state returns immediately to IDLE with all outputs at reset values. The in-flight command is discarded and no response is produced.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=3'b000 … OP_MUL=3'b111;
  - state enum {IDLE, EXEC, MUL, RESP};
  - default WIDTH localparam.
- Sub-module alu_seq_mul: iterative WIDTH-step shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, product[2*WIDTH-1:0].
  - Same clk/rst_n.
- The responder keeps the FSM, operand registers, single-cycle ops and the handshakes.

Test Plan:
- Reset release, then ADD a=0010 b=0101 with rsp_ready=1 → cmd_ready 1 after reset; rsp_result=0111, carry=0, zero=0; rsp_valid high after edge N+1.
- SUB a=0101 b=0010 → 0011, carry=0. SUB a=0010 b=0101 → 1101, carry=1.
- ADD a=1111 b=0001 → result=0000, carry=1, zero=1.
- MUL a=0111 b=0011 → 0101, carry=1; rsp_valid first high after edge N+5; busy=1 from edge N to the response handshake.
- Backpressure: rsp_ready=0 for 3 cycles after rsp_valid → outputs stable, cmd_ready=0. A cmd_valid pulse (XOR 1010/0110) in that window is not accepted. After the handshake, re-presenting it → 1100.
- Reset mid-MUL: rst_n low 2 cycles after accept → all outputs at reset values. No response is ever produced for that command. The next ADD 0001+0001 → 0010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default widths for the ALU
// command responder and its iterative multiplier.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int OPW_DEFAULT   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command and response handshake bundle between an ALU command initiator
// (master) and the responder (slave).
interface alu_cmd_responder_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int OPW   = OPW_DEFAULT
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, busy
    );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// done and product are presented combinationally during the final step cycle.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               running;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // product is only meaningful while done is high
    assign done     = running && (count == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_responder.sv
// ALU command responder: accepts one {a, b, op} command at a time, computes
// the result (iteratively for multiply) and returns result plus flags.
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int OPW   = OPW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_responder_if.slave  bus
);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [OPW-1:0]     op_q;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     alu_out;
    logic [WIDTH:0]     mul_out;

    // Single-cycle ops; returns {carry, result}.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [OPW-1:0]   op
    );
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OPW'(OP_ADD): r = {1'b0, a} + {1'b0, b};
            OPW'(OP_SUB): r = {a < b, a - b};
            OPW'(OP_AND): r = {1'b0, a & b};
            OPW'(OP_OR):  r = {1'b0, a | b};
            OPW'(OP_XOR): r = {1'b0, a ^ b};
            OPW'(OP_NOT): r = {1'b0, ~a};
            OPW'(OP_SHL): begin
                if (32'(b) < WIDTH) begin
                    r = {1'b0, a << b};
                end
            end
            default:      r = '0;
        endcase
        return r;
    endfunction

    // Multiply overflow: any bit set in the upper half of the full product.
    function automatic logic [WIDTH:0] mul_fold(input logic [2*WIDTH-1:0] p);
        return {|p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]};
    endfunction

    assign alu_out   = alu_eval(a_q, b_q, op_q);
    assign mul_out   = mul_fold(mul_product);
    assign mul_start = (state == EXEC) && (op_q == OPW'(OP_MUL));

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        a_q           <= bus.cmd_a;
                        b_q           <= bus.cmd_b;
                        op_q          <= bus.cmd_op;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= EXEC;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (op_q == OPW'(OP_MUL)) begin
                        state <= MUL;
                    end else begin
                        bus.rsp_result <= alu_out[WIDTH-1:0];
                        bus.rsp_carry  <= alu_out[WIDTH];
                        bus.rsp_zero   <= (alu_out[WIDTH-1:0] == '0);
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        bus.rsp_result <= mul_out[WIDTH-1:0];
                        bus.rsp_carry  <= mul_out[WIDTH];
                        bus.rsp_zero   <= (mul_out[WIDTH-1:0] == '0);
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed bench for alu_cmd_responder with a cycle-level reference model
// checked every cycle and literal expectations for each directed vector.
module tb_alu_cmd_responder;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_responder_if #(.WIDTH(W), .OPW(3)) bus_if ();

    alu_cmd_responder #(.WIDTH(W), .OPW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_ready;
    logic       m_valid;
    logic       m_busy;
    logic [3:0] m_res;
    logic       m_carry;
    logic [4:0] m_pend;
    int         m_wait;

    // Plain-arithmetic reference: returns {carry, result}
    function automatic logic [4:0] ref_eval(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op);
        int ia, ib, v;
        logic c;
        ia = int'(a);
        ib = int'(b);
        v  = 0;
        c  = 1'b0;
        case (op)
            3'd0: begin v = ia + ib; c = (v > 15); end
            3'd1: begin v = ia - ib; c = (ia < ib); if (v < 0) v = v + 16; end
            3'd2: v = ia & ib;
            3'd3: v = ia | ib;
            3'd4: v = ia ^ ib;
            3'd5: v = 15 - ia;
            3'd6: v = (ib >= 4) ? 0 : ((ia * (1 << ib)) % 16);
            default: begin v = ia * ib; c = (v > 15); end
        endcase
        return {c, 4'(v % 16)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_res   <= 4'd0;
            m_carry <= 1'b0;
            m_pend  <= 5'd0;
            m_wait  <= 0;
        end else if (m_valid) begin
            if (bus_if.rsp_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_carry <= m_pend[4];
                m_res   <= m_pend[3:0];
            end
        end else if (m_ready && bus_if.cmd_valid) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_pend  <= ref_eval(bus_if.cmd_a, bus_if.cmd_b, bus_if.cmd_op);
            m_wait  <= (bus_if.cmd_op == 3'd7) ? W + 1 : 1;
        end else if (!m_busy) begin
            m_ready <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vecs[13] = '{
        '{4'b0010, 4'b0101, 3'd0, 4'b0111, 1'b0, 1},
        '{4'b0101, 4'b0010, 3'd1, 4'b0011, 1'b0, 1},
        '{4'b0010, 4'b0101, 3'd1, 4'b1101, 1'b1, 1},
        '{4'b1111, 4'b0001, 3'd0, 4'b0000, 1'b1, 1},
        '{4'b0111, 4'b0011, 3'd7, 4'b0101, 1'b1, 5},
        '{4'b1100, 4'b1010, 3'd2, 4'b1000, 1'b0, 1},
        '{4'b1100, 4'b1010, 3'd3, 4'b1110, 1'b0, 1},
        '{4'b0101, 4'b1111, 3'd5, 4'b1010, 1'b0, 1},
        '{4'b0011, 4'b0010, 3'd6, 4'b1100, 1'b0, 1},
        '{4'b0011, 4'b0100, 3'd6, 4'b0000, 1'b0, 1},
        '{4'b1001, 4'b0001, 3'd6, 4'b0010, 1'b0, 1},
        '{4'b1111, 4'b1111, 3'd7, 4'b0001, 1'b1, 5},
        '{4'b0010, 4'b0011, 3'd7, 4'b0110, 1'b0, 5}
    };

    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic r;
        bit   taken;
        taken = 1'b0;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        bus_if.cmd_op    = op;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = bus_if.cmd_ready;
            @(posedge clk);
            if (r) begin
                taken = 1'b1;
                break;
            end
        end
        #1;
        bus_if.cmd_valid = 1'b0;
        check("cmd_accepted", 32'(taken), 32'd1);
    endtask

    // Returns at the negedge where rsp_valid is first seen high.
    task automatic wait_rsp(input string name, input logic [3:0] res, input logic c, input int lat);
        int  seen;
        bit  got;
        seen = -1;
        got  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid === 1'b1) begin
                seen = i;
                got  = 1'b1;
                break;
            end
        end
        check({name, "_rsp_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, 32'(seen), 32'(lat));
        check({name, "_result"}, 32'(bus_if.rsp_result), 32'(res));
        check({name, "_carry"}, 32'(bus_if.rsp_carry), 32'(c));
        check({name, "_zero"}, 32'(bus_if.rsp_zero), 32'(res == 4'd0));
        check({name, "_busy"}, 32'(bus_if.busy), 32'd1);
    endtask

    initial begin
        int vcount;
        logic [3:0] held;
        rst_n            = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_a     = 4'd0;
        bus_if.cmd_b     = 4'd0;
        bus_if.cmd_op    = 3'd0;
        bus_if.rsp_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                check("mdl_cmd_ready", 32'(bus_if.cmd_ready), 32'(m_ready));
                check("mdl_rsp_valid", 32'(bus_if.rsp_valid), 32'(m_valid));
                check("mdl_busy", 32'(bus_if.busy), 32'(m_busy));
                if (m_valid || !rst_n) begin
                    check("mdl_result", 32'(bus_if.rsp_result), 32'(m_valid ? m_res : 4'd0));
                    check("mdl_carry", 32'(bus_if.rsp_carry), 32'(m_valid ? m_carry : 1'b0));
                    check("mdl_zero", 32'(bus_if.rsp_zero), 32'(m_valid && (m_res == 4'd0)));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_result", 32'(bus_if.rsp_result), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(bus_if.cmd_ready), 32'd1);

        foreach (vecs[i]) begin
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_rsp($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].lat);
            @(posedge clk);
            #1;
        end

        // Backpressure with an ignored command pulse
        bus_if.rsp_ready = 1'b0;
        send_cmd(4'b0011, 4'b0100, 3'd0);
        wait_rsp("bp_add", 4'b0111, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bus_if.cmd_valid = (k == 0);
            bus_if.cmd_a     = 4'b1010;
            bus_if.cmd_b     = 4'b0110;
            bus_if.cmd_op    = 3'd4;
            @(negedge clk);
            check("bp_hold_valid", 32'(bus_if.rsp_valid), 32'd1);
            check("bp_hold_result", 32'(bus_if.rsp_result), 32'b0111);
            check("bp_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        send_cmd(4'b1010, 4'b0110, 3'd4);
        wait_rsp("bp_xor", 4'b1100, 1'b0, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply
        send_cmd(4'b0111, 4'b0011, 3'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        check("mid_rst_result", 32'(bus_if.rsp_result), 32'd0);
        check("mid_rst_carry", 32'(bus_if.rsp_carry), 32'd0);
        check("mid_rst_zero", 32'(bus_if.rsp_zero), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid !== 1'b0) vcount++;
        end
        check("no_rsp_after_rst", 32'(vcount), 32'd0);
        send_cmd(4'b0001, 4'b0001, 3'd0);
        wait_rsp("post_rst_add", 4'b0010, 1'b0, 1);
        held = bus_if.rsp_result;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_done", 32'(bus_if.rsp_valid), 32'd0);
        check("post_rst_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("post_rst_held", 32'(held), 32'b0010);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
